tt_um_drops: RTL and testbench

TT_UM_DROPS -- requirements
Module: tt_um_drops

---
 rtl/tt_um_drops.sv | 107 ++++++++++
 tb/tb_tt_um_drops.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_drops.sv
// tt_um_drops: 8x8 LED catch game where drops fall once per 8192-clock tick onto a player paddle.
//   clk, rst_n (async, active-low); ena ignored; ui_in[0]=right, [1]=left, [2]=restart, [3]=show score;
//   uo_out = scanned row LED pattern or score; uio_out = {0, tick, game_over, lives[1:0], scan_row[2:0]};
//   uio_oe = all outputs; uio_in unused.
module tt_um_drops (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, press;
  logic [12:0] presc_q, presc_d;
  logic [7:0]  lfsr_q, lfsr_d, score_q, score_d, pattern;
  logic [2:0]  scan_q, scan_d, pad_q, pad_d, row_q, row_d, col_q, col_d;
  logic [1:0]  lives_q, lives_d;
  logic        act_q, act_d, go_q, go_d, tick, drop_vis;
  logic        unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};
  always_comb begin
    press    = sync2_q & ~prev_q;
    tick     = presc_q == 13'h1FFF;
    sync1_d  = ui_in[2:0];
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    presc_d  = presc_q + 13'd1;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    scan_d   = scan_q + 3'd1;
    pad_d    = pad_q;
    act_d    = act_q;
    row_d    = row_q;
    col_d    = col_q;
    score_d  = score_q;
    lives_d  = lives_q;
    go_d     = go_q;
    if (go_q) begin
      if (press[2]) begin
        go_d    = 1'b0;
        act_d   = 1'b0;
        row_d   = 3'd0;
        col_d   = 3'd0;
        lives_d = 2'd3;
        score_d = 8'd0;
        pad_d   = 3'd3;
      end
    end else begin
      if (press[0] && !press[1] && pad_q != 3'd7) pad_d = pad_q + 3'd1;
      else if (press[1] && !press[0] && pad_q != 3'd0) pad_d = pad_q - 3'd1;
      if (tick) begin
        if (!act_q) begin
          act_d = 1'b1;
          row_d = 3'd0;
          col_d = lfsr_q[2:0];
        end else if (row_q != 3'd7) begin
          row_d = row_q + 3'd1;
        end else begin
          // landing tick: resolve catch/miss against the paddle as it stood before this edge
          act_d = 1'b0;
          row_d = 3'd0;
          if (col_q == pad_q) score_d = score_q + {7'd0, score_q != 8'hFF};
          else begin
            lives_d = lives_q - 2'd1;
            go_d    = lives_q == 2'd1;
          end
        end
      end
    end
    drop_vis = act_q & ~go_q & (row_q == scan_q);
    pattern  = (drop_vis ? 8'd1 << col_q : 8'd0) | (scan_q == 3'd7 ? 8'd1 << pad_q : 8'd0);
    uo_out   = ui_in[3] ? score_q : pattern;
    uio_out  = {1'b0, tick, go_q, lives_q, scan_q};
    uio_oe   = 8'hFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= 3'd0;
      sync2_q <= 3'd0;
      prev_q  <= 3'd0;
      presc_q <= 13'd0;
      lfsr_q  <= 8'hA5;
      scan_q  <= 3'd0;
      pad_q   <= 3'd3;
      act_q   <= 1'b0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      score_q <= 8'd0;
      lives_q <= 2'd3;
      go_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
      scan_q  <= scan_d;
      pad_q   <= pad_d;
      act_q   <= act_d;
      row_q   <= row_d;
      col_q   <= col_d;
      score_q <= score_d;
      lives_q <= lives_d;
      go_q    <= go_d;
    end
endmodule

// File: tb/tb_tt_um_drops.sv
// tb_tt_um_drops: directed scoreboard bench for the drop-catching game.
module tb_tt_um_drops;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00, uo_out, uio_out, uio_oe;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] q[$];
  logic [2:0] m_pad = 3'd3, m_row = 3'd0, m_col = 3'd0;
  logic m_act = 1'b0, m_go = 1'b0;
  logic [7:0] m_score = 8'd0;
  logic [1:0] m_lives = 2'd3;
  tt_um_drops dut (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
                   .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
  initial begin
    #10ms;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [7:0] lfsr_at(int n);
    logic [7:0] l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction
  function automatic logic [7:0] exp_row(int r);
    logic [7:0] p = 8'h00;
    if (m_act && !m_go && m_row == r[2:0]) p[m_col] = 1'b1;
    if (r == 7) p[m_pad] = 1'b1;
    return p;
  endfunction
  task automatic push(logic [31:0] v);
    q.push_back(v);
  endtask
  task automatic pop_check(string tag, logic [31:0] obs);
    logic [31:0] e;
    e = q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_row(int r, string tag);
    int k = 0;
    while (uio_out[2:0] != r[2:0] && k < 16) begin step(1); k++; end
    push(32'(r)); pop_check({tag, "_scan"}, 32'(uio_out[2:0]));
    push(32'(exp_row(r))); pop_check(tag, 32'(uo_out));
  endtask
  task automatic check_status(string tag);
    push(32'({m_go, m_lives})); pop_check(tag, 32'(uio_out[5:3]));
  endtask
  task automatic check_score(string tag);
    ui_in[3] = 1'b1; #1;
    push(32'(m_score)); pop_check(tag, 32'(uo_out));
    ui_in[3] = 1'b0; #1;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    m_pad = 3'd3; m_row = 3'd0; m_col = 3'd0; m_act = 1'b0; m_go = 1'b0; m_score = 8'd0; m_lives = 2'd3;
  endtask
  task automatic press(int b);
    ui_in[b] = 1'b1; step(4); ui_in[b] = 1'b0; step(4);
    if (b == 2) begin
      if (m_go) begin m_go = 1'b0; m_lives = 2'd3; m_score = 8'd0; m_pad = 3'd3; m_act = 1'b0; end
    end else if (!m_go) begin
      m_pad = b == 0 ? (m_pad == 3'd7 ? 3'd7 : m_pad + 3'd1) : (m_pad == 3'd0 ? 3'd0 : m_pad - 3'd1);
    end
  endtask
  task automatic tick(input bit fast, output logic [2:0] sc, output int at);
    int k = 0;
    logic [7:0] l;
    if (fast) begin
      force dut.presc_q = 13'd8190;
      #1;
      release dut.presc_q;
    end
    while (!uio_out[6] && k < 9000) begin step(1); k++; end
    push(32'd1); pop_check("tick", 32'(uio_out[6]));
    at = cyc;
    l = lfsr_at(cyc);
    sc = l[2:0];
    step(1);
  endtask
  task automatic spawn(bit fast, string tag);
    logic [2:0] sc;
    int at;
    tick(fast, sc, at);
    m_act = 1'b1; m_row = 3'd0; m_col = sc;
    check_row(0, tag);
  endtask
  task automatic align(bit catch_it);
    if (catch_it) begin
      while (m_pad < m_col) press(0);
      while (m_pad > m_col) press(1);
    end else if (m_pad == m_col) press(m_pad == 3'd0 ? 0 : 1);
  endtask
  task automatic land_drop(string tag);
    logic [2:0] sc;
    int at;
    while (m_row < 3'd7) begin tick(1'b1, sc, at); m_row++; check_row(int'(m_row), tag); end
    tick(1'b1, sc, at);
    if (m_col == m_pad) m_score = m_score == 8'hFF ? m_score : m_score + 8'd1;
    else begin m_lives--; m_go = m_lives == 2'd0; end
    m_act = 1'b0;
    check_status({tag, "_status"});
    check_score({tag, "_score"});
    check_row(7, {tag, "_row7"});
  endtask
  initial begin
    logic [2:0] sc;
    int at;
    step(3);
    push(32'hFF); pop_check("reset_oe", 32'(uio_oe));
    check_status("reset_status");
    push(32'd0); pop_check("reset_scan_held", 32'(uio_out[2:0]));
    push(32'd0); pop_check("reset_row0", 32'(uo_out));
    check_score("reset_score");
    rst_n = 1'b1;
    check_row(7, "idle_row7");
    check_row(3, "idle_row3");
    for (int i = 0; i < 2; i++) begin
      ui_in = 8'h02; step(2000); m_pad = 3'd2; check_row(7, "hold_left");
      ui_in = 8'h01; step(2000); m_pad = 3'd3; check_row(7, "hold_right");
    end
    ui_in = 8'h00;
    reset_dut();
    for (int i = 0; i < 5; i++) press(1);
    check_row(7, "left_to_0");
    press(1);
    check_row(7, "left_sat");
    for (int i = 0; i < 8; i++) press(0);
    check_row(7, "right_sat");
    ui_in[1:0] = 2'b11; step(4); ui_in[1:0] = 2'b00; step(4);
    check_row(7, "both_no_move");
    reset_dut();
    tick(1'b0, sc, at);
    push(32'd8191); pop_check("first_tick_cycle", 32'(at));
    push(32'd0); pop_check("tick_one_clock", 32'(uio_out[6]));
    m_act = 1'b1; m_row = 3'd0; m_col = sc;
    check_row(0, "spawn_natural");
    tick(1'b0, sc, at);
    push(32'd16383); pop_check("second_tick_cycle", 32'(at));
    m_row = 3'd1;
    check_row(1, "fall_natural");
    land_drop("first_land");
    press(2);
    check_status("restart_ignored");
    for (int d = 0; d < 4 && !m_go; d++) begin
      spawn(1'b1, "miss_spawn");
      align(1'b0);
      land_drop("miss");
    end
    push(32'd1); pop_check("game_over_flag", 32'(uio_out[5]));
    press(1);
    press(0);
    check_row(7, "frozen_paddle");
    tick(1'b1, sc, at);
    check_status("frozen_status");
    check_row(0, "frozen_no_drop");
    press(2);
    check_status("restart_status");
    check_score("restart_score");
    check_row(7, "restart_paddle");
    spawn(1'b1, "catch_spawn");
    align(1'b1);
    land_drop("catch");
    spawn(1'b1, "mid_spawn");
    for (int i = 0; i < 3; i++) begin tick(1'b1, sc, at); m_row++; check_row(int'(m_row), "mid_fall"); end
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    m_pad = 3'd3; m_row = 3'd0; m_col = 3'd0; m_act = 1'b0; m_go = 1'b0; m_score = 8'd0; m_lives = 2'd3;
    check_status("async_status");
    check_score("async_score");
    push(32'd0); pop_check("async_scan", 32'(uio_out[2:0]));
    push(32'd0); pop_check("async_row0", 32'(uo_out));
    push(32'd0); pop_check("async_tick", 32'(uio_out[6]));
    step(2);
    rst_n = 1'b1;
    check_row(7, "post_reset_row7");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
